// File: rtl/sync_param_fifo_if.sv
// Handshake bundle between a producer/consumer (master) and sync_param_fifo (slave).
// Widths must match the DSIZE/ASIZE the FIFO is built with.
interface sync_param_fifo_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic             flush;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             wfull;
  logic             walmost_full;
  logic             ralmost_empty;
  logic [ASIZE:0]   level;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, winc, wdata, rinc,
    input  rdata, rempty, wfull, walmost_full, ralmost_empty, level, overflow, underflow
  );

  modport slave (
    input  flush, winc, wdata, rinc,
    output rdata, rempty, wfull, walmost_full, ralmost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_param_fifo.sv
// Single-clock FIFO with fill level, almost flags, sticky overflow/underflow and sync flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module sync_param_fifo #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input logic             clk,
  input logic             rst_n,
  sync_param_fifo_if.slave bus
);

  localparam int             DEPTH      = 1 << ASIZE;
  localparam logic [ASIZE:0] PTR_ONE    = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE:0] DEPTH_LVL  = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AFULL_LVL  = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY_LVL = AEMPTY_TH[ASIZE:0];

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] rptr_q, rptr_d;
  logic [ASIZE:0] level_q, level_d;
  logic           rempty_q, rempty_d;
  logic           wfull_q, wfull_d;
  logic           walmost_full_q, walmost_full_d;
  logic           ralmost_empty_q, ralmost_empty_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;

  logic wr_en;
  logic rd_en;

  // Acceptance is judged against the registered flags of the current cycle,
  // so a full FIFO rejects a write even when a read frees a slot on the same edge.
  assign wr_en = bus.winc && !wfull_q  && !bus.flush;
  assign rd_en = bus.rinc && !rempty_q && !bus.flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;

    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PTR_ONE;
      if (rd_en) rptr_d = rptr_q + PTR_ONE;
      unique case ({wr_en, rd_en})
        2'b10:   level_d = level_q + PTR_ONE;
        2'b01:   level_d = level_q - PTR_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    rempty_d        = (wptr_d == rptr_d);
    wfull_d         = (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]) && (wptr_d[ASIZE] != rptr_d[ASIZE]);
    walmost_full_d  = (level_d >= AFULL_LVL);
    ralmost_empty_d = (level_d <= AEMPTY_LVL);
    overflow_d      = bus.flush ? 1'b0 : (overflow_q  || (bus.winc && wfull_q));
    underflow_d     = bus.flush ? 1'b0 : (underflow_q || (bus.rinc && rempty_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      level_q         <= '0;
      rempty_q        <= 1'b1;
      wfull_q         <= 1'b0;
      walmost_full_q  <= 1'b0;
      ralmost_empty_q <= 1'b1;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      level_q         <= level_d;
      rempty_q        <= rempty_d;
      wfull_q         <= wfull_d;
      walmost_full_q  <= walmost_full_d;
      ralmost_empty_q <= ralmost_empty_d;
      overflow_q      <= overflow_d;
      underflow_q     <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset and flush; stale words are unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[ASIZE-1:0]] <= bus.wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rdata = mem[rptr_q[ASIZE-1:0]];
`else
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata_q <= '0;
    else if (rd_en) rdata_q <= mem[rptr_q[ASIZE-1:0]];
  end

  assign bus.rdata = rdata_q;
`endif

  assign bus.rempty        = rempty_q;
  assign bus.wfull         = wfull_q;
  assign bus.walmost_full  = walmost_full_q;
  assign bus.ralmost_empty = ralmost_empty_q;
  assign bus.level         = level_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;

  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n) level_q <= DEPTH_LVL);
  a_level_ptrs:  assert property (@(posedge clk) disable iff (!rst_n) level_q == (wptr_q - rptr_q));
  a_flags_excl:  assert property (@(posedge clk) disable iff (!rst_n) !(rempty_q && wfull_q));

endmodule

// File: tb/tb_sync_param_fifo.sv
// Directed bench for sync_param_fifo; expected values are hand-derived per vector.
// Works in both read modes (SYNC_FIFO_FWFT_EN defined or not).
module tb_sync_param_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sync_param_fifo_if #(.DSIZE(8), .ASIZE(4)) bus ();

  sync_param_fifo #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.flush = 1'b0; bus.winc = 1'b0; bus.rinc = 1'b0; bus.wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [7:0] d);
    bus.winc = 1'b1; bus.wdata = d;
    tick();
    bus.winc = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk(tag, bus.rdata, exp);
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
`else
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    chk(tag, bus.rdata, exp);
`endif
  endtask

  task automatic push_pop_chk(input string tag, input logic [7:0] d, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk(tag, bus.rdata, exp);
`endif
    bus.winc = 1'b1; bus.rinc = 1'b1; bus.wdata = d;
    tick();
    bus.winc = 1'b0; bus.rinc = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    chk(tag, bus.rdata, exp);
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
`ifndef SYNC_FIFO_FWFT_EN
    chk({tag, "_rdata"}, bus.rdata, 0);
`endif
    chk({tag, "_rempty"}, bus.rempty, 1);
    chk({tag, "_wfull"}, bus.wfull, 0);
    chk({tag, "_level"}, bus.level, 0);
    chk({tag, "_aempty"}, bus.ralmost_empty, 1);
    chk({tag, "_afull"}, bus.walmost_full, 0);
    chk({tag, "_ovf"}, bus.overflow, 0);
    chk({tag, "_unf"}, bus.underflow, 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // 1: basic order and level
    do_reset();
    chk_reset_vals("rst");
    push(8'h11);
    push(8'h22);
    chk("t1_aempty_at2", bus.ralmost_empty, 1);
    push(8'h33);
    chk("t1_level3", bus.level, 3);
    chk("t1_aempty_at3", bus.ralmost_empty, 0);
    chk("t1_rempty", bus.rempty, 0);
    pop_chk("t1_rd0", 8'h11);
    pop_chk("t1_rd1", 8'h22);
    pop_chk("t1_rd2", 8'h33);
    chk("t1_level0", bus.level, 0);
    chk("t1_rempty_end", bus.rempty, 1);

    // 2: fill to full, overflow sticky
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      push(8'(k - 1));
      chk($sformatf("t2_level_%0d", k), bus.level, k);
      chk($sformatf("t2_afull_%0d", k), bus.walmost_full, (k >= 12) ? 1 : 0);
    end
    chk("t2_wfull", bus.wfull, 1);
    chk("t2_ovf_pre", bus.overflow, 0);
    push(8'h99);
    chk("t2_level_17", bus.level, 16);
    chk("t2_ovf", bus.overflow, 1);
    repeat (3) tick();
    chk("t2_ovf_hold", bus.overflow, 1);
    for (int k = 0; k < 16; k++) pop_chk($sformatf("t2_rd%0d", k), 8'(k));
    chk("t2_rempty", bus.rempty, 1);
    chk("t2_ovf_after_drain", bus.overflow, 1);
    chk("t2_unf", bus.underflow, 0);

    // 3: empty read, then simultaneous write/read on empty
    do_reset();
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    chk("t3_unf", bus.underflow, 1);
    chk("t3_level", bus.level, 0);
    chk("t3_rempty", bus.rempty, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("t3_rdata_hold", bus.rdata, 0);
`endif
    bus.winc = 1'b1; bus.rinc = 1'b1; bus.wdata = 8'hA5;
    tick();
    bus.winc = 1'b0; bus.rinc = 1'b0;
    chk("t3_level_both", bus.level, 1);
    chk("t3_rempty_both", bus.rempty, 0);
    pop_chk("t3_rd", 8'hA5);
    chk("t3_unf_hold", bus.underflow, 1);

    // 4: simultaneous on full, then on half-full
    do_reset();
    for (int k = 0; k < 16; k++) push(8'(k));
    push_pop_chk("t4_full_rd", 8'hEE, 8'h00);
    chk("t4_level15", bus.level, 15);
    chk("t4_ovf", bus.overflow, 1);
    chk("t4_wfull", bus.wfull, 0);
    for (int k = 1; k <= 7; k++) pop_chk($sformatf("t4_rd%0d", k), 8'(k));
    chk("t4_level8", bus.level, 8);
    push_pop_chk("t4_half_rd", 8'h77, 8'h08);
    chk("t4_level_half", bus.level, 8);
    for (int k = 9; k <= 15; k++) pop_chk($sformatf("t4_rd%0d", k), 8'(k));
    pop_chk("t4_rd_last", 8'h77);
    chk("t4_rempty", bus.rempty, 1);

    // 5: 40 interleaved transfers (pointers wrap), then flush
    do_reset();
    for (int k = 0; k < 40; k++) begin
      push(8'(k));
      pop_chk($sformatf("t5_rd%0d", k), 8'(k));
    end
    chk("t5_level0", bus.level, 0);
    bus.rinc = 1'b1;
    tick();
    bus.rinc = 1'b0;
    for (int k = 0; k < 17; k++) push(8'(8'h80 + k));
    chk("t5_ovf_pre", bus.overflow, 1);
    chk("t5_unf_pre", bus.underflow, 1);
    bus.flush = 1'b1; bus.winc = 1'b1; bus.wdata = 8'h5A;
    tick();
    bus.flush = 1'b0; bus.winc = 1'b0;
    chk("t5_fl_level", bus.level, 0);
    chk("t5_fl_rempty", bus.rempty, 1);
    chk("t5_fl_wfull", bus.wfull, 0);
    chk("t5_fl_ovf", bus.overflow, 0);
    chk("t5_fl_unf", bus.underflow, 0);
    chk("t5_fl_aempty", bus.ralmost_empty, 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("t5_fl_rdata_hold", bus.rdata, 8'h27);
`endif
    tick();
    chk("t5_fl_still_empty", bus.rempty, 1);
    push(8'h66);
    pop_chk("t5_post_flush_rd", 8'h66);

    // 6: asynchronous reset mid-burst
    do_reset();
    push(8'hC1);
    push(8'hC2);
    pop_chk("t6_rd", 8'hC1);
    bus.winc = 1'b1; bus.wdata = 8'hC3;
    tick();
    tick();
    chk("t6_level_pre", bus.level, 3);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    bus.winc = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    chk("t6_level_post", bus.level, 0);
    push(8'h42);
    pop_chk("t6_rd_post", 8'h42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
